digit_entry: RTL and testbench

- Upstream input stage for the combination-lock FSM.
- Conditions the raw pushbutton and the 4-bit switch bank, then emits exactly one qualified digit strobe per clean press.
- Digits 0-9 are forwarded to the lock FSM as digit_o plus digit_valid_o.
- Values 10-15 raise a reject pulse instead, so the lock never sees a non-decimal entry.
- Contact bounce and held keys never produce duplicate entries.

---
 rtl/digit_entry.sv | 163 ++++++++++++++++
 tb/tb_digit_entry.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_entry.sv
// digit_entry: input conditioning ahead of the combination-lock FSM.
// Synchronises the raw pushbutton and switch bank, debounces the key and
// issues one qualified strobe per clean press: digits 0-9 go out on
// digit_o/digit_valid_o, values 10-15 raise reject_o instead.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   key_n          raw pushbutton, active low, asynchronous
//   sw[3:0]        raw switch value, asynchronous
//   digit_o        last accepted digit, holds between strobes
//   digit_valid_o  one-cycle strobe, digit_o valid in the same cycle
//   reject_o       one-cycle strobe for a press with sw > 9
//   armed_o        high while a new press can be accepted
//
// Optional build macro: DIGIT_ENTRY_AUTO_REPEAT_EN adds a repeat timer that
// re-strobes every REPEAT_CYCLES clocks while the key is held.
//
// state    | meaning
// DISARMED | after reset; waits for a released key before arming
// IDLE     | armed, waiting for a debounced press
// HELD     | press accepted, waiting for debounced release

module digit_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_CYCLES   = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_n,
   input  logic [3:0] sw,
   output logic [3:0] digit_o,
   output logic       digit_valid_o,
   output logic       reject_o,
   output logic       armed_o
);

   typedef enum logic [1:0] {DISARMED, IDLE, HELD} state_t;

   localparam logic [9:0] DEB_LAST = 10'(DEBOUNCE_CYCLES - 1);

   state_t     state;
   logic       key_s1, key_s2;
   logic [3:0] sw_s1, sw_s2;
   logic       deb_pressed;
   logic [9:0] deb_cnt;
   logic       key_pressed;
   logic       differs;
   logic       flip;
   logic       press_evt;
   logic       release_evt;

   // Key synchronisers reset to the pressed level: until the pin has really
   // been sampled, a held key must not be mistaken for a released one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1 <= 1'b0;
         key_s2 <= 1'b0;
         sw_s1  <= 4'd0;
         sw_s2  <= 4'd0;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
      end
   end

   always_comb begin
      key_pressed = ~key_s2;
      differs     = (key_pressed != deb_pressed);
      flip        = differs && (deb_cnt == DEB_LAST);
      press_evt   = flip && !deb_pressed;
      release_evt = flip && deb_pressed;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_pressed <= 1'b0;
         deb_cnt     <= 10'd0;
      end else if (flip) begin
         deb_pressed <= ~deb_pressed;
         deb_cnt     <= 10'd0;
      end else if (differs) begin
         deb_cnt <= deb_cnt + 10'd1;
      end else begin
         deb_cnt <= 10'd0;
      end
   end

`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
   localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
   logic [15:0] rpt_cnt;
`else
   logic unused_repeat;
   assign unused_repeat = (REPEAT_CYCLES != 0);
`endif

   // Strobes are acted on at the same edge the debounced level flips, so the
   // pulse lands one cycle after the debouncer's terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= DISARMED;
         digit_o       <= 4'd0;
         digit_valid_o <= 1'b0;
         reject_o      <= 1'b0;
         armed_o       <= 1'b0;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
         rpt_cnt       <= 16'd0;
`endif
      end else begin
         digit_valid_o <= 1'b0;
         reject_o      <= 1'b0;
         case (state)
            DISARMED: begin
               if (!deb_pressed && !key_pressed) begin
                  state   <= IDLE;
                  armed_o <= 1'b1;
               end
            end
            IDLE: begin
               if (press_evt) begin
                  if (sw_s2 <= 4'd9) begin
                     digit_o       <= sw_s2;
                     digit_valid_o <= 1'b1;
                  end else begin
                     reject_o <= 1'b1;
                  end
                  state   <= HELD;
                  armed_o <= 1'b0;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
                  rpt_cnt <= 16'd0;
`endif
               end
            end
            HELD: begin
               if (release_evt) begin
                  state   <= IDLE;
                  armed_o <= 1'b1;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
                  rpt_cnt <= 16'd0;
               end else if (rpt_cnt == RPT_LAST) begin
                  rpt_cnt <= 16'd0;
                  if (sw_s2 <= 4'd9) begin
                     digit_o       <= sw_s2;
                     digit_valid_o <= 1'b1;
                  end else begin
                     reject_o <= 1'b1;
                  end
               end else begin
                  rpt_cnt <= rpt_cnt + 16'd1;
`endif
               end
            end
            default: begin
               state   <= DISARMED;
               armed_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_entry.sv
module tb_digit_entry;
   localparam int D = 4;
   localparam int R = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_n = 1'b1;
   logic [3:0] sw = 4'd0;
   logic [3:0] digit_o;
   logic       digit_valid_o;
   logic       reject_o;
   logic       armed_o;

   int vectors = 0;
   int miscompares = 0;

   digit_entry dut (
      .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw(sw),
      .digit_o(digit_o), .digit_valid_o(digit_valid_o),
      .reject_o(reject_o), .armed_o(armed_o)
   );

   always #5 clk = ~clk;

   // Reference model: history of pin values per clock since reset release.
   // Entry i of the queues holds what the pin showed at edge i+1.
   bit         key_at[$];
   logic [3:0] sw_at[$];
   bit         m_deb_pressed;
   bit         m_waiting;
   bit         m_holding;
   bit         m_armed;
   bit         m_valid;
   bit         m_reject;
   logic [3:0] m_digit;
   int         m_held_cycles;

   // The logic sees a pin value two edges after it is sampled; before that it
   // sees the reset value of the synchroniser (key pressed, sw zero).
   function automatic bit seen_key(int e);
      return (e >= 3) ? key_at[e-3] : 1'b0;
   endfunction

   function automatic logic [3:0] seen_sw(int e);
      return (e >= 3) ? sw_at[e-3] : 4'd0;
   endfunction

   task automatic model_reset();
      key_at.delete();
      sw_at.delete();
      m_deb_pressed = 0;
      m_waiting = 1;
      m_holding = 0;
      m_armed = 0;
      m_valid = 0;
      m_reject = 0;
      m_digit = 4'd0;
      m_held_cycles = 0;
   endtask

   task automatic model_emit(logic [3:0] v);
      if (v <= 4'd9) begin
         m_digit = v;
         m_valid = 1;
      end else begin
         m_reject = 1;
      end
   endtask

   task automatic model_edge(bit k, logic [3:0] s);
      int e;
      bit flip;
      key_at.push_back(k);
      sw_at.push_back(s);
      e = key_at.size();
      // the debounced level changes once D consecutive seen samples disagree
      flip = 0;
      if (e >= D) begin
         flip = 1;
         for (int i = e - D + 1; i <= e; i++)
            if ((!seen_key(i)) == m_deb_pressed) flip = 0;
      end
      m_valid = 0;
      m_reject = 0;
      if (m_waiting) begin
         if (!m_deb_pressed && seen_key(e)) begin
            m_waiting = 0;
            m_armed = 1;
         end
      end else if (!m_holding) begin
         if (flip && !m_deb_pressed) begin
            model_emit(seen_sw(e));
            m_holding = 1;
            m_armed = 0;
            m_held_cycles = 0;
         end
      end else begin
         if (flip && m_deb_pressed) begin
            m_holding = 0;
            m_armed = 1;
         end else begin
            m_held_cycles++;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
            if (m_held_cycles % R == 0) model_emit(seen_sw(e));
`endif
         end
      end
      if (flip) m_deb_pressed = !m_deb_pressed;
   endtask

   // Drive at the falling edge, let one rising edge pass, return at the next
   // falling edge where outputs are stable.
   task automatic step(bit k, logic [3:0] s);
      key_n = k;
      sw = s;
      @(posedge clk);
      model_edge(k, s);
      @(negedge clk);
   endtask

   task automatic do_reset(bit k, logic [3:0] s);
      @(negedge clk);
      rst_n = 1'b0;
      key_n = k;
      sw = s;
      model_reset();
      #1;
      vectors++;
      if ({armed_o, digit_valid_o, reject_o, digit_o} !== 7'b0) begin
         miscompares++;
         $display("FAIL reset_values got %b exp %b", {armed_o, digit_valid_o, reject_o, digit_o}, 7'b0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(1'b1, 4'd0);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'd0);
         vectors++;
         if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
            miscompares++;
            $display("FAIL reset_arm cyc %0d got %b exp %b", i,
                     {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
         end
      end
      vectors++;
      if (armed_o !== 1'b1 || digit_o !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_armed got armed=%b digit=%0d exp armed=1 digit=0", armed_o, digit_o);
      end
   endtask

   task automatic test_digit();
      logic [3:0] vals[2] = '{4'd3, 4'd2};
      foreach (vals[j]) begin
         int pulses = 0;
         int at = -1;
         for (int i = 1; i <= 12; i++) begin
            step(1'b0, vals[j]);
            if (digit_valid_o === 1'b1) begin
               pulses++;
               if (at < 0) at = i;
            end
            vectors++;
            if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
               miscompares++;
               $display("FAIL digit_cycle v=%0d cyc %0d got %b exp %b", vals[j], i,
                        {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
            end
         end
         vectors++;
         if (pulses !== 1 || at !== 6 || digit_o !== vals[j]) begin
            miscompares++;
            $display("FAIL digit_press got pulses=%0d edge=%0d digit=%0d exp pulses=1 edge=6 digit=%0d",
                     pulses, at, digit_o, vals[j]);
         end
         for (int i = 0; i < 10; i++) step(1'b1, vals[j]);
      end
   endtask

   task automatic test_reject();
      int rej = 0;
      int val = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 4'd12);
         if (reject_o === 1'b1) rej++;
         if (digit_valid_o === 1'b1) val++;
         vectors++;
         if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
            miscompares++;
            $display("FAIL reject_cycle cyc %0d got %b exp %b", i,
                     {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
         end
      end
      vectors++;
      if (rej !== 1 || val !== 0 || digit_o !== 4'd2) begin
         miscompares++;
         $display("FAIL reject_press got rej=%0d valid=%0d digit=%0d exp rej=1 valid=0 digit=2", rej, val, digit_o);
      end
      for (int i = 0; i < 10; i++) step(1'b1, 4'd12);
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < 3; i++) begin
            step((i == 2) ? 1'b1 : 1'b0, 4'd5);
            if (digit_valid_o === 1'b1 || reject_o === 1'b1) pulses++;
            vectors++;
            if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
               miscompares++;
               $display("FAIL bounce_cycle n=%0d i=%0d got %b exp %b", n, i,
                        {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
            end
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 4'd5);
         if (digit_valid_o === 1'b1 || reject_o === 1'b1) pulses++;
      end
      vectors++;
      if (pulses !== 0 || armed_o !== 1'b1) begin
         miscompares++;
         $display("FAIL bounce_result got pulses=%0d armed=%b exp pulses=0 armed=1", pulses, armed_o);
      end
   endtask

   task automatic test_reset_held();
      int pulses = 0;
      do_reset(1'b0, 4'd7);
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 4'd7);
         if (digit_valid_o === 1'b1 || reject_o === 1'b1) pulses++;
         vectors++;
         if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
            miscompares++;
            $display("FAIL held_reset cyc %0d got %b exp %b", i,
                     {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
         end
      end
      vectors++;
      if (pulses !== 0 || armed_o !== 1'b0) begin
         miscompares++;
         $display("FAIL held_reset_ignored got pulses=%0d armed=%b exp pulses=0 armed=0", pulses, armed_o);
      end
      for (int i = 0; i < 10; i++) step(1'b1, 4'd7);
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 4'd7);
         if (digit_valid_o === 1'b1) pulses++;
      end
      vectors++;
      if (pulses !== 1 || digit_o !== 4'd7) begin
         miscompares++;
         $display("FAIL held_reset_press got pulses=%0d digit=%0d exp pulses=1 digit=7", pulses, digit_o);
      end
      for (int i = 0; i < 10; i++) step(1'b1, 4'd7);
   endtask

   task automatic test_hold();
      int pulses = 0;
      int exp_pulses;
`ifdef DIGIT_ENTRY_AUTO_REPEAT_EN
      exp_pulses = 4;
`else
      exp_pulses = 1;
`endif
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 4'd9);
         if (digit_valid_o === 1'b1) begin
            pulses++;
            vectors++;
            if (digit_o !== 4'd9) begin
               miscompares++;
               $display("FAIL hold_digit got %0d exp 9", digit_o);
            end
         end
         vectors++;
         if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
            miscompares++;
            $display("FAIL hold_cycle cyc %0d got %b exp %b", i,
                     {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
         end
      end
      vectors++;
      if (pulses !== exp_pulses) begin
         miscompares++;
         $display("FAIL hold_count got %0d exp %0d", pulses, exp_pulses);
      end
      for (int i = 0; i < 10; i++) step(1'b1, 4'd9);
   endtask

   task automatic test_random();
      bit k = 1'b1;
      int run = 0;
      bit prev_pulse = 0;
      logic [3:0] s;
      for (int i = 0; i < 3000; i++) begin
         if (run == 0) begin
            k = $urandom_range(0, 1);
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 150) : $urandom_range(1, 8);
         end
         run--;
         s = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) begin
            do_reset(k, s);
            prev_pulse = 0;
         end
         step(k, s);
         vectors++;
         if ({armed_o, digit_valid_o, reject_o, digit_o} !== {m_armed, m_valid, m_reject, m_digit}) begin
            miscompares++;
            $display("FAIL random cyc %0d got %b exp %b", i,
                     {armed_o, digit_valid_o, reject_o, digit_o}, {m_armed, m_valid, m_reject, m_digit});
         end
         if (digit_valid_o === 1'b1 || reject_o === 1'b1) begin
            vectors++;
            if (prev_pulse || (digit_valid_o === 1'b1 && reject_o === 1'b1)) begin
               miscompares++;
               $display("FAIL random_strobe_rule cyc %0d got valid=%b reject=%b prev=%b exp isolated single strobe",
                        i, digit_valid_o, reject_o, prev_pulse);
            end
         end
         prev_pulse = (digit_valid_o === 1'b1 || reject_o === 1'b1);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_digit();
      test_reject();
      test_bounce();
      test_reset_held();
      test_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
